pipe_shell: RTL and testbench
=============================

# pipe_shell

Parametrised, elastic in-order pipeline shell for the next-generation MIPS datapath. It carries DEPTH stages of instruction payload with per-stage valid bits and bubble collapsing, and has valid/ready handshakes at both ends. It provides built-in forwarding lookup and late-result (load-use) interlock, plus selective flush of younger stages. It replaces hard-wired stage registers and the external stall/forward wiring between decode and writeback.

## Interface
- WIDTH, 32, payload/data width
- DEPTH, 5, number of stages (≥2); stage 0 youngest, stage DEPTH-1 retires
- REG_AW, 5, register-id width; register 0 never written or forwarded
- NSRC, 2, source operands checked per incoming entry
- LATE_READY, 3, first stage where a late entry's data is valid (1 ≤ LATE_READY ≤ DEPTH-1)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- in_valid  in  1  incoming entry present
- in_ready  out  1  entry accepted on this edge when in_valid && in_ready
- in_data  in  WIDTH  payload (ALU result)
- in_dest  in  REG_AW  destination register
- in_wr  in  1  entry writes in_dest
- in_late  in  1  data not valid until LATE_READY (load)
- in_src  in  NSRC*REG_AW  source registers of incoming entry, src i at [i*REG_AW +: REG_AW]
- ld_data  in  WIDTH  late result, captured into a late entry entering stage LATE_READY
- flush_valid  in  1  flush request
- flush_stage  in  clog2(DEPTH)  flush stages 0..flush_stage
- fwd_hit  out  NSRC  forwarding available for src i
- fwd_data  out  NSRC*WIDTH  forwarded value for src i
- out_valid  out  1  stage DEPTH-1 holds a valid entry
- out_ready  in  1  consumer takes entry on this edge
- out_data / out_dest / out_wr  out  WIDTH / REG_AW / 1  retiring entry fields
- occ  out  clog2(DEPTH+1)  number of valid stages

## Operation
- Each stage holds valid, data, dest, wr, late. Only valid is architecturally meaningful. Fields of invalid stages are don't-care but reset to 0.
- Advance rule: move[DEPTH-1] = valid[DEPTH-1] && out_ready. For k < DEPTH-1, stage k moves into k+1 when valid[k] && (!valid[k+1] || move[k+1]). Bubbles collapse, so a stalled output does not block younger entries until they reach it.
- Stage k+1 that receives no entry and whose own entry moves becomes invalid.
- Late capture: an entry with late=1 moving from LATE_READY-1 into LATE_READY loads data ← ld_data and clears late. Entries with late=0 pass data unchanged.
- Match for src s at stage k: valid && wr && dest==s && s≠0.
- Youngest match: the lowest-index matching stage decides the result.
  - If that stage's late=1 (data not yet valid), this is a hazard: fwd_hit[i]=0.
  - Otherwise fwd_hit[i]=1 and fwd_data[i] = that stage's data.
  - No match gives fwd_hit[i]=0 and fwd_data[i]=0.
- in_ready = !RST && !flush_valid && no hazard on any src && (!valid[0] || move[0]). in_ready is combinational.
- Accepted entry enters stage 0 with in_late stored; late is forced to 0 when !in_wr.
- Flush: at the edge with flush_valid, entries in stages 0..flush_stage are discarded and never appear downstream. Older stages advance normally. No input is accepted that cycle. flush_stage ≥ DEPTH-1 flushes everything, including an entry retiring that edge; that retirement is treated as not taken.
- occ counts valid stages after each edge.

## Timing
- Reset: all valid=0, all fields 0. out_valid=0, out_data/out_dest/out_wr=0, occ=0, fwd_hit=0, fwd_data=0, in_ready=0 while RST is high. From the first cycle after reset, in_ready=1 absent a hazard.
- Reset mid-operation discards every entry on that edge. Inputs are ignored on that edge.
- Latency: an entry accepted at edge n shows out_valid=1 after edge n+DEPTH-1 if unobstructed. Throughput is 1 entry/cycle.
- fwd_* and in_ready are combinational from current stage state and in_src, with no cycle of delay.
- Simultaneous events: flush overrides accept. Retire plus accept in the same cycle keeps occ unchanged. ld_data is sampled only on the capture edge.

## Test plan
- Defaults, out_ready=1: accept 5 entries on back-to-back edges, data 1..5. Required: out_valid first after edge 4 post first accept, data 1,2,3,4,5 on consecutive cycles, occ peaks at 5.
- out_ready=0 with 2 entries in stages 0 and 3. Required: after 1 edge they occupy stages 1 and 4. After another they occupy 2 and 4. in_ready=0 once all 5 stages are valid.
- Load-use: late entry dest=8 in stage 1, in_src={8,0}. Required: in_ready=0. On the edge it enters stage 3 with ld_data=0xDEAD it forwards, so next cycle fwd_hit[0]=1 and fwd_data=0xDEAD.
- Youngest wins: dest=4 entries in stage 0 (data 0xA) and stage 2 (data 0xB), src=4. Required: fwd_data=0xA. With src=0: fwd_hit=0 even if dest=0 entries exist.
- Stages 0–4 full, flush_stage=1 with in_valid=1. Required: stages 0–2 invalid after the edge, input not accepted, older entries retire normally, occ=2.
- Assert RST for one edge while the pipe is full. Required: occ=0, out_valid=0 next cycle, then in_ready=1.

Source files
------------

// File: rtl/pipe_shell.sv
// Elastic in-order pipeline shell: DEPTH payload stages with bubble collapsing,
// youngest-match forwarding, load-use interlock, late-data capture and selective flush.
module pipe_shell #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int REG_AW     = 5,
  parameter int NSRC       = 2,
  parameter int LATE_READY = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [REG_AW-1:0]            in_dest,
  input  logic                         in_wr,
  input  logic                         in_late,
  input  logic [NSRC*REG_AW-1:0]       in_src,
  input  logic [WIDTH-1:0]             ld_data,
  input  logic                         flush_valid,
  input  logic [$clog2(DEPTH)-1:0]     flush_stage,
  output logic [NSRC-1:0]              fwd_hit,
  output logic [NSRC*WIDTH-1:0]        fwd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [REG_AW-1:0]            out_dest,
  output logic                         out_wr,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld;
  logic [WIDTH-1:0]  dat [DEPTH];
  logic [REG_AW-1:0] dst [DEPTH];
  logic [DEPTH-1:0]  wrt;
  logic [DEPTH-1:0]  lat;
  logic [DEPTH-1:0]  move;
  logic              hazard;
  logic              accept;

  function automatic logic flushHit(input int k, input logic fv, input logic [$clog2(DEPTH)-1:0] fs);
    return fv && (k <= int'(fs));
  endfunction

  // A stage is blocked only when every older stage up to the output is full and stalled
  always_comb begin : advance
    logic stall;
    stall = !out_ready;
    move  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move[k] = vld[k] && !stall;
      stall   = stall && vld[k];
    end
  end

  // Later loop iterations are younger stages, so the youngest match wins
  always_comb begin : fwdLookup
    logic [REG_AW-1:0] srcId;
    logic              hit;
    logic              haz;
    logic [WIDTH-1:0]  data;
    fwd_hit  = '0;
    fwd_data = '0;
    hazard   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      srcId = in_src[i*REG_AW +: REG_AW];
      hit   = 1'b0;
      haz   = 1'b0;
      data  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (vld[k] && wrt[k] && (dst[k] == srcId) && (|srcId)) begin
          haz  = lat[k];
          hit  = !lat[k];
          data = lat[k] ? '0 : dat[k];
        end
      end
      fwd_hit[i]                  = hit;
      fwd_data[i*WIDTH +: WIDTH] = data;
      hazard                      = hazard || haz;
    end
  end

  assign in_ready = !RST && !flush_valid && !hazard && (!vld[0] || move[0]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(vld[k]);
  end

  // Stage registers: stage k takes stage k-1 unless that entry is being flushed
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld[k] <= 1'b0;
        dat[k] <= '0;
        dst[k] <= '0;
        wrt[k] <= 1'b0;
        lat[k] <= 1'b0;
      end
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (move[k-1] && !flushHit(k - 1, flush_valid, flush_stage)) begin
          vld[k] <= 1'b1;
          dst[k] <= dst[k-1];
          wrt[k] <= wrt[k-1];
          if (k == LATE_READY && lat[k-1]) dat[k] <= ld_data;
          else                             dat[k] <= dat[k-1];
          lat[k] <= (k == LATE_READY) ? 1'b0 : lat[k-1];
        end else if (move[k] || flushHit(k, flush_valid, flush_stage)) begin
          vld[k] <= 1'b0;
        end
      end
      if (accept) begin
        vld[0] <= 1'b1;
        dat[0] <= in_data;
        dst[0] <= in_dest;
        wrt[0] <= in_wr;
        lat[0] <= in_late && in_wr;
      end else if (move[0] || flushHit(0, flush_valid, flush_stage)) begin
        vld[0] <= 1'b0;
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_dest  = dst[DEPTH-1];
  assign out_wr    = wrt[DEPTH-1];

endmodule

// File: tb/tb_pipe_shell.sv
// Directed, table-driven bench for pipe_shell with default parameters.
module tb_pipe_shell;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_dest;
  logic        in_wr;
  logic        in_late;
  logic [9:0]  in_src;
  logic [31:0] ld_data;
  logic        flush_valid;
  logic [2:0]  flush_stage;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_wr;
  logic [2:0]  occ;

  int nChecks = 0;
  int nErrors = 0;

  pipe_shell dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .in_wr(in_wr), .in_late(in_late), .in_src(in_src), .ld_data(ld_data),
    .flush_valid(flush_valid), .flush_stage(flush_stage),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_wr(out_wr), .occ(occ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] iv, d, dst, wr, late, s0, s1, ld, fv, fs, ordy;
    logic [31:0] eRdy, eHit, eFd0, eFd1, eOv, eOd, eDst, eWr, eOcc;
  } vec_t;

  localparam int NV = 56;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s (row %0d): actual %0h required %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [4:0] dest,
                       input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_dest   = dest;
    in_wr     = 1'b1;
    in_late   = 1'b0;
    in_src    = '0;
    ld_data   = '0;
    flush_valid = 1'b0;
    flush_stage = '0;
    out_ready = ordy;
  endtask

  initial begin
    //          iv  d       dst wr lt  s0 s1 ld       fv fs or   rdy hit fd0     fd1    ov od      dst wr occ
    tbl[0]  = '{1, 'h1,    1,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[1]  = '{1, 'h2,    2,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[2]  = '{1, 'h3,    3,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 2};
    tbl[3]  = '{1, 'h4,    4,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 3};
    tbl[4]  = '{1, 'h5,    5,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 4};
    tbl[5]  = '{0, 0,      0,  1, 0,  5, 1, 0,      0, 0, 1,   1,  3,  'h5,    'h1,   1, 'h1,    1,  1, 5};
    tbl[6]  = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h2,    2,  1, 4};
    tbl[7]  = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h3,    3,  1, 3};
    tbl[8]  = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h4,    4,  1, 2};
    tbl[9]  = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h5,    5,  1, 1};
    // output stalled: bubbles collapse behind the retiring stage
    tbl[10] = '{1, 'h11,   6,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[11] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[12] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[13] = '{1, 'h22,   7,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[14] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     0, 0,      0,  0, 2};
    tbl[15] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'h11,   6,  1, 2};
    tbl[16] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'h11,   6,  1, 2};
    tbl[17] = '{1, 'h33,   9,  1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'h11,   6,  1, 2};
    tbl[18] = '{1, 'h44,   10, 1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'h11,   6,  1, 3};
    tbl[19] = '{1, 'h55,   11, 1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'h11,   6,  1, 4};
    tbl[20] = '{1, 'h66,   12, 1, 0,  0, 0, 0,      0, 0, 0,   0,  0,  0,      0,     1, 'h11,   6,  1, 5};
    tbl[21] = '{1, 'h66,   12, 1, 0,  9, 6, 0,      0, 0, 0,   0,  3,  'h33,   'h11,  1, 'h11,   6,  1, 5};
    tbl[22] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h11,   6,  1, 5};
    tbl[23] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h22,   7,  1, 4};
    tbl[24] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h33,   9,  1, 3};
    tbl[25] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h44,   10, 1, 2};
    tbl[26] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h55,   11, 1, 1};
    // load-use interlock and late capture at stage 3
    tbl[27] = '{1, 'h77,   8,  1, 1,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[28] = '{1, 'h99,   13, 1, 0,  8, 0, 0,      0, 0, 1,   0,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[29] = '{1, 'h99,   13, 1, 0,  8, 0, 'hBEEF, 0, 0, 1,   0,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[30] = '{1, 'h99,   13, 1, 0,  8, 0, 'hDEAD, 0, 0, 1,   0,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[31] = '{0, 0,      0,  1, 0,  8, 0, 0,      0, 0, 1,   1,  1,  'hDEAD, 0,     0, 0,      0,  0, 1};
    tbl[32] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'hDEAD, 8,  1, 1};
    // late with wr=0 keeps its own data
    tbl[33] = '{1, 'h123,  8,  0, 1,  0, 0, 'hFFFF, 0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[34] = '{0, 0,      0,  1, 0,  8, 0, 'hFFFF, 0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[35] = '{0, 0,      0,  1, 0,  0, 0, 'hFFFF, 0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[36] = '{0, 0,      0,  1, 0,  0, 0, 'hFFFF, 0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[37] = '{0, 0,      0,  1, 0,  0, 0, 'hFFFF, 0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[38] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'h123,  8,  0, 1};
    // youngest match wins; register 0 never forwards
    tbl[39] = '{1, 'hB,    4,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[40] = '{1, 'hC,    0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[41] = '{1, 'hA,    4,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 2};
    tbl[42] = '{0, 0,      0,  1, 0,  4, 0, 0,      0, 0, 1,   1,  1,  'hA,    0,     0, 0,      0,  0, 3};
    tbl[43] = '{0, 0,      0,  1, 0,  4, 4, 0,      0, 0, 1,   1,  3,  'hA,    'hA,   0, 0,      0,  0, 3};
    // fill, then flush stages 0..1 with a competing input
    tbl[44] = '{1, 'hD1,   14, 1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'hB,    4,  1, 3};
    tbl[45] = '{1, 'hD2,   15, 1, 0,  0, 0, 0,      0, 0, 0,   1,  0,  0,      0,     1, 'hB,    4,  1, 4};
    tbl[46] = '{1, 'hEE,   16, 1, 0,  0, 0, 0,      1, 1, 1,   0,  0,  0,      0,     1, 'hB,    4,  1, 5};
    tbl[47] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'hC,    0,  1, 2};
    tbl[48] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     1, 'hA,    4,  1, 1};
    // flush of the whole pipe, including the retiring entry
    tbl[49] = '{1, 'h31,   1,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};
    tbl[50] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[51] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[52] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[53] = '{1, 'h32,   2,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 1};
    tbl[54] = '{1, 'h33,   3,  1, 0,  0, 0, 0,      1, 4, 1,   0,  0,  0,      0,     1, 'h31,   1,  1, 2};
    tbl[55] = '{0, 0,      0,  1, 0,  0, 0, 0,      0, 0, 1,   1,  0,  0,      0,     0, 0,      0,  0, 0};

    RST = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    in_src = {5'd3, 5'd1};
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_in_ready", -1, 32'(in_ready), 0);
    chk("rst_out_valid", -1, 32'(out_valid), 0);
    chk("rst_out_data", -1, out_data, 0);
    chk("rst_out_dest", -1, 32'(out_dest), 0);
    chk("rst_out_wr", -1, 32'(out_wr), 0);
    chk("rst_occ", -1, 32'(occ), 0);
    chk("rst_fwd_hit", -1, 32'(fwd_hit), 0);
    chk("rst_fwd_data", -1, fwd_data[31:0] | fwd_data[63:32], 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge CLK);
      in_valid    = tbl[i].iv[0];
      in_data     = tbl[i].d;
      in_dest     = tbl[i].dst[4:0];
      in_wr       = tbl[i].wr[0];
      in_late     = tbl[i].late[0];
      in_src      = {tbl[i].s1[4:0], tbl[i].s0[4:0]};
      ld_data     = tbl[i].ld;
      flush_valid = tbl[i].fv[0];
      flush_stage = tbl[i].fs[2:0];
      out_ready   = tbl[i].ordy[0];
      #1;
      chk("in_ready", i, 32'(in_ready), tbl[i].eRdy);
      chk("fwd_hit", i, 32'(fwd_hit), tbl[i].eHit);
      if (tbl[i].eHit[0]) chk("fwd_data0", i, fwd_data[31:0], tbl[i].eFd0);
      if (tbl[i].eHit[1]) chk("fwd_data1", i, fwd_data[63:32], tbl[i].eFd1);
      chk("out_valid", i, 32'(out_valid), tbl[i].eOv);
      if (tbl[i].eOv[0]) begin
        chk("out_data", i, out_data, tbl[i].eOd);
        chk("out_dest", i, 32'(out_dest), tbl[i].eDst);
        chk("out_wr", i, 32'(out_wr), tbl[i].eWr);
      end
      chk("occ", i, 32'(occ), tbl[i].eOcc);
    end

    // Mid-operation reset with a full, stalled pipe
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      drive(1'b1, 32'h40 + 32'(j), 5'(j + 1), 1'b0);
    end
    @(negedge CLK);
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("full_occ", 100, 32'(occ), 5);
    chk("full_in_ready", 100, 32'(in_ready), 0);
    @(negedge CLK);
    RST = 1'b1;
    drive(1'b1, 32'h99, 5'd9, 1'b1);
    #1;
    chk("rst_mid_in_ready", 101, 32'(in_ready), 0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    #1;
    chk("post_rst_occ", 102, 32'(occ), 0);
    chk("post_rst_out_valid", 102, 32'(out_valid), 0);
    chk("post_rst_in_ready", 102, 32'(in_ready), 1);
    @(negedge CLK);
    #1;
    chk("post_rst_occ2", 103, 32'(occ), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
